// File: rtl/vga_sync.sv
// VGA timing generator: pixel-enable divider, h/v counters, registered syncs,
// active-area flag and a free-running completed-frame counter.
module vga_sync #(
  parameter int PIX_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] dummy
);

  localparam int DW = $clog2(PIX_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);

  localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0] divider_q, divider_d;
  logic [9:0]    h_count_q, h_count_d;
  logic [9:0]    v_count_q, v_count_d;
  logic [9:0]    frame_q, frame_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          h_end, v_end;

  assign p_tick = (divider_q == DIV_MAX);
  // >= rather than == so an inconsistent parameter set still wraps to 0
  assign h_end  = (h_count_q >= H_MAX);
  assign v_end  = (v_count_q >= V_MAX);

  always_comb begin
    divider_d = p_tick ? '0 : divider_q + 1'b1;
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    frame_d   = frame_q;
    if (p_tick) begin
      h_count_d = h_end ? 10'd0 : h_count_q + 10'd1;
      if (h_end) begin
        v_count_d = v_end ? 10'd0 : v_count_q + 10'd1;
        if (v_end) frame_d = frame_q + 10'd1;
      end
    end
    // syncs decode the next counter values so the flops align with x/y
    hsync_d = !((h_count_d >= HS_START) && (h_count_d <= HS_END));
    vsync_d = !((v_count_d >= VS_START) && (v_count_d <= VS_END));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divider_q <= '0;
      h_count_q <= '0;
      v_count_q <= '0;
      frame_q   <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      divider_q <= divider_d;
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      frame_q   <= frame_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (h_count_q < H_VIS) && (v_count_q < V_VIS);
  assign x        = h_count_q;
  assign y        = v_count_q;
  assign dummy    = frame_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: a full-size instance for line timing and a shrunken-timing
// instance for frame/vsync/frame-counter behaviour within a short run.
module tb_vga_sync;
  logic clk = 1'b0;
  logic reset, reset_s;
  always #5 clk = ~clk;

  logic       hsync, vsync, video_on, p_tick;
  logic [9:0] x, y, dummy;
  logic       hsync_s, vsync_s, video_on_s, p_tick_s;
  logic [9:0] x_s, y_s, dummy_s;
  logic [7:0] rgb;

  vga_sync dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .p_tick(p_tick), .x(x), .y(y), .dummy(dummy)
  );

  // small timing: H_TOTAL 15 (sync x 10..12), V_TOTAL 11 (sync y 7..8)
  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .clk(clk), .reset(reset_s), .hsync(hsync_s), .vsync(vsync_s),
    .video_on(video_on_s), .p_tick(p_tick_s), .x(x_s), .y(y_s), .dummy(dummy_s)
  );

  assign rgb = video_on ? 8'h11 : 8'h00;

  int tests = 0;
  int fails = 0;
  int t = 0;
  int ts = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_big(input int target);
    while (t < target) begin
      step();
      t++;
    end
  endtask

  function automatic logic [63:0] model_s(input int k);
    int xs, ys, ds;
    logic hs, vs, vo, pt;
    xs = (k / 2) % 15;
    ys = (k / 30) % 11;
    ds = (k / 330) % 1024;
    hs = !(xs >= 10 && xs <= 12);
    vs = !(ys >= 7 && ys <= 8);
    vo = (xs < 8) && (ys < 6);
    pt = (k % 2) == 1;
    return {30'd0, 10'(xs), 10'(ys), 10'(ds), hs, vs, vo, pt};
  endfunction

  function automatic logic [63:0] obs_s();
    return {30'd0, x_s, y_s, dummy_s, hsync_s, vsync_s, video_on_s, p_tick_s};
  endfunction

  task automatic run_small(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      ts++;
      check(tag, obs_s(), model_s(ts));
    end
  endtask

  initial begin
    int low_cnt, tick_cnt;
    reset = 1'b1;
    reset_s = 1'b1;
    repeat (5) step();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_p_tick", p_tick, 0);
    check("rst_dummy", dummy, 0);
    check("rst_video_on", video_on, 1);

    reset = 1'b0;
    t = 0;
    go_big(1);
    check("rel1_p_tick", p_tick, 1);
    check("rel1_x", x, 0);
    go_big(2);
    check("rel2_p_tick", p_tick, 0);
    check("rel2_x", x, 1);
    go_big(3);
    check("rel3_p_tick", p_tick, 1);

    go_big(1279);
    check("x639_x", x, 639);
    check("x639_video", video_on, 1);
    check("x639_rgb", rgb, 8'h11);
    go_big(1280);
    check("x640_video", video_on, 0);
    check("x640_rgb", rgb, 8'h00);
    go_big(1311);
    check("x655_hsync", hsync, 1);
    go_big(1312);
    check("x656_x", x, 656);
    check("x656_hsync", hsync, 0);
    go_big(1503);
    check("x751_hsync", hsync, 0);
    go_big(1504);
    check("x752_hsync", hsync, 1);
    go_big(1599);
    check("x799_x", x, 799);
    check("x799_y", y, 0);
    check("x799_video", video_on, 0);
    go_big(1600);
    check("wrap_x", x, 0);
    check("wrap_y", y, 1);
    check("wrap_video", video_on, 1);
    check("wrap_rgb", rgb, 8'h11);

    low_cnt = 0;
    tick_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      step();
      t++;
      if (!hsync) low_cnt++;
      if (p_tick) tick_cnt++;
    end
    check("hsync_low_clks", low_cnt, 192);
    check("line_p_ticks", tick_cnt, 800);
    check("line2_y", y, 2);
    check("line2_x", x, 0);

    go_big(4000);
    check("midline_x", x, 400);
    reset = 1'b1;
    step();
    check("midrst_x", x, 0);
    check("midrst_y", y, 0);
    check("midrst_hsync", hsync, 1);
    check("midrst_vsync", vsync, 1);
    check("midrst_dummy", dummy, 0);
    check("midrst_p_tick", p_tick, 0);
    reset = 1'b0;
    t = 0;
    go_big(1);
    check("resume_p_tick", p_tick, 1);
    go_big(2);
    check("resume_x", x, 1);
    go_big(1600);
    check("resume_y", y, 1);

    // shrunken-timing instance: two full frames, every clock
    check("s_rst", obs_s(), model_s(0));
    reset_s = 1'b0;
    ts = 0;
    run_small(330, "s_frame1");
    check("s_vwrap_y", y_s, 0);
    check("s_vwrap_dummy", dummy_s, 1);
    run_small(330, "s_frame2");
    check("s_dummy2", dummy_s, 2);
    run_small(130, "s_frame3");
    check("s_mid_x", x_s, 5);
    check("s_mid_y", y_s, 4);
    reset_s = 1'b1;
    step();
    check("s_midrst", obs_s(), model_s(0));
    reset_s = 1'b0;
    ts = 0;
    run_small(40, "s_resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
